// File: rtl/npc_pkg.sv
// ============================================================================
// Module      : npc_pkg
// Description : Shared encodings and default addresses for the next-PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

    typedef enum logic [1:0] {
        JMP_NONE = 2'b00,
        JMP_J    = 2'b01,
        JMP_JR   = 2'b10,
        JMP_JAL  = 2'b11
    } jump_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b010,
        BR_BNE  = 3'b011,
        BR_BLEZ = 3'b100,
        BR_BGTZ = 3'b101,
        BR_BLTZ = 3'b110,
        BR_BGEZ = 3'b111
    } branch_e;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;
    localparam logic [31:0] c_exc_vec  = 32'h0000_4180;

endpackage

`default_nettype wire

// File: rtl/npc_branch_cond.sv
// ============================================================================
// Module      : npc_branch_cond
// Description : Combinational branch-taken evaluation from ALU zero/sign flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_branch_cond
    import npc_pkg::*;
(
    input  logic [2:0] branch,
    input  logic       zero,
    input  logic       neg,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (branch)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = ~zero;
            BR_BLEZ: taken = zero | neg;
            BR_BGTZ: taken = ~zero & ~neg;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = ~neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/npc_unit.sv
// ============================================================================
// Module      : npc_unit
// Description : PC register and next-fetch-address selection with EPC,
//               JAL link register and misaligned-target trap.
//               Optional branch delay slot: define NPC_DELAY_SLOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_unit
    import npc_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_reset_pc),
    parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(c_exc_vec)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_ready,
    input  logic              ctrl_valid,
    input  logic [1:0]        jump,
    input  logic [2:0]        branch,
    input  logic              zero,
    input  logic              neg,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic [ADDR_W-1:0] epc,
    output logic              misalign
);

    // Low 28 bits come from the J/JAL index; upper bits from the delay-slot PC.
    localparam logic [ADDR_W-1:0] c_seg_mask = ADDR_W'(28'hFFF_FFFF);
`ifdef NPC_DELAY_SLOT_EN
    localparam logic [ADDR_W-1:0] c_link_off = ADDR_W'(8);
`else
    localparam logic [ADDR_W-1:0] c_link_off = ADDR_W'(4);
`endif

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic [ADDR_W-1:0] r_link;
    logic [ADDR_W-1:0] r_epc;
    logic              r_misalign;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_redir_tgt;
    logic              w_redir;
    logic              w_redir_ok;
    logic              w_is_jal;
    logic              w_taken;

    npc_branch_cond u_branch_cond (
        .branch (branch),
        .zero   (zero),
        .neg    (neg),
        .taken  (w_taken)
    );

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_jump_tgt = (w_pc_plus4 & ~c_seg_mask) | ADDR_W'({instr_index, 2'b00});

    // Jumps override any branch encoding carried alongside them.
    always_comb begin
        w_redir     = 1'b0;
        w_is_jal    = 1'b0;
        w_redir_tgt = '0;
        if (ctrl_valid && (jump != JMP_NONE)) begin
            w_redir     = 1'b1;
            w_is_jal    = (jump == JMP_JAL);
            w_redir_tgt = (jump == JMP_JR) ? reg_target : w_jump_tgt;
        end else if (ctrl_valid && w_taken) begin
            w_redir     = 1'b1;
            w_redir_tgt = br_target;
        end
    end

`ifdef NPC_DELAY_SLOT_EN
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_tgt;

    // A redirect issued from a delay slot is illegal and dropped.
    assign w_redir_ok = w_redir & ~r_pend;
`else
    assign w_redir_ok = w_redir;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_link     <= '0;
            r_epc      <= '0;
            r_misalign <= 1'b0;
`ifdef NPC_DELAY_SLOT_EN
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
`endif
        end else begin
            r_pc_valid <= 1'b1;
            r_misalign <= 1'b0;
            if (exc_req) begin
                r_pc  <= EXC_VEC;
                r_epc <= r_pc;
`ifdef NPC_DELAY_SLOT_EN
                r_pend <= 1'b0;
`endif
            end else if (eret) begin
                r_pc <= r_epc;
`ifdef NPC_DELAY_SLOT_EN
                r_pend <= 1'b0;
`endif
            end else if (w_redir_ok) begin
                if (w_redir_tgt[1:0] != 2'b00) begin
                    r_pc       <= EXC_VEC;
                    r_epc      <= w_redir_tgt;
                    r_misalign <= 1'b1;
                end else begin
                    if (w_is_jal) begin
                        r_link <= r_pc + c_link_off;
                    end
`ifdef NPC_DELAY_SLOT_EN
                    r_pend     <= 1'b1;
                    r_pend_tgt <= w_redir_tgt;
                    r_pc       <= w_pc_plus4;
`else
                    r_pc       <= w_redir_tgt;
`endif
                end
            end else if (r_pc_valid && if_ready) begin
`ifdef NPC_DELAY_SLOT_EN
                if (r_pend) begin
                    r_pc   <= r_pend_tgt;
                    r_pend <= 1'b0;
                end else begin
                    r_pc <= w_pc_plus4;
                end
`else
                r_pc <= w_pc_plus4;
`endif
            end
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pc_valid;
    assign pc_plus4  = w_pc_plus4;
    assign link_addr = r_link;
    assign epc       = r_epc;
    assign misalign  = r_misalign;

endmodule

`default_nettype wire
